debounce_sync: RTL
==================

Name: debounce_sync

Overview:
- Input conditioning stage placed directly upstream of the serial sequence-detector FSM.
- Takes a raw asynchronous level such as a pushbutton or external pin, and synchronizes it into the clk domain.
- Debounces the synchronized level with a consecutive-stable-cycles counter.
- Outputs a clean registered level that drives the detector's serial input, plus single-cycle edge pulses and a saturating glitch counter for debug.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer chain (legal range 2..4).
- STABLE_CYCLES, 4, consecutive synchronized samples at the new level required before q changes (legal range 1..255).
- GW, 8, width of the glitch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low; 0 resets the block immediately, release is synchronous to clk by the system.
- din  input  1  raw asynchronous level.
- q  output  1  debounced level; feeds the downstream detector input.
- rise  output  1  one-cycle pulse, high in the first cycle q is 1 after being 0.
- fall  output  1  one-cycle pulse, high in the first cycle q is 0 after being 1.
- glitch_cnt  output  GW  count of aborted transitions; saturates at all-ones.

Behaviour:
- Reset (reset=0), asynchronous:
  - synchronizer flops = 0, state = LOW, cnt = 0.
  - q = 0, rise = 0, fall = 0, glitch_cnt = 0.
  - Reset asserted mid-count discards the partial count and returns to LOW with no pulses.
- Synchronizer:
  - din is shifted through SYNC_STAGES flops; s denotes the last stage.
  - Only s is used by the FSM; din is never used combinationally.
- FSM states, 2-bit encoded, evaluated each rising clk edge:
  - LOW: q=0. If s=1 → RISING with cnt=1. If STABLE_CYCLES=1 instead → HIGH directly, q←1, rise←1.
  - RISING: if s=0 → LOW, cnt←0, glitch_cnt increments. If s=1 and cnt=STABLE_CYCLES-1 → HIGH, q←1, rise←1, cnt←0. Otherwise cnt←cnt+1.
  - HIGH: q=1. Mirror of LOW: s=0 → FALLING with cnt=1. If STABLE_CYCLES=1 → LOW directly, q←0, fall←1.
  - FALLING: mirror of RISING with levels inverted; completion → LOW, q←0, fall←1. Abort (s=1) → HIGH, glitch_cnt increments.
  - Unused encoding → LOW, q←0, no pulse.
- Timing:
  - q changes only after s has been sampled at the new level on STABLE_CYCLES consecutive edges.
  - Latency from din stable before edge E0 to q updated is SYNC_STAGES+STABLE_CYCLES edges (6 with defaults).
- Pulses:
  - rise and fall are registered and default to 0 every cycle.
  - Each is high for exactly one cycle, the same cycle q first shows its new value.
  - rise and fall are never high together.
- glitch_cnt:
  - Increments by 1 on each abort.
  - Holds at 2^GW-1; does not wrap.
- Simultaneous events: an abort and a completion cannot occur on the same edge (they are mutually exclusive by s). A single-cycle low inside a high run restarts counting from cnt=1 on the next s=1 sample.
- All outputs are registered; there are no combinational paths from din.

Test Plan:
1. Reset then clean step (defaults): hold reset=0 for 3 cycles → q=0, glitch_cnt=0. Release, then din 0→1 before edge E0 and held → q=1 and rise=1 after edge E5 only; rise=0 after E6.
2. Bounce on press: din high 2 cycles, low 1, high 2, low 1, then high steady → q stays 0 through bounces, glitch_cnt=2, q rises 6 edges after the final steady rise, single rise pulse.
3. Release path: from q=1, din→0 held → fall=1 for one cycle at edge 6, q=0, rise never asserted.
4. Reset mid-count: din→1, assert reset=0 asynchronously between edges 3 and 4 → q, cnt, and state cleared immediately, no rise pulse. After release with din still 1 → full 6-edge latency from scratch.
5. STABLE_CYCLES=1, SYNC_STAGES=2: din step → q=1 after 3 edges. A one-cycle din pulse produces a one-cycle q pulse with matching rise/fall pulses.
6. Saturation with GW=2: generate 5 aborted rises → glitch_cnt reads 1,2,3,3,3; q stays 0 throughout.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a raw asynchronous level into clk, debounces it
// with a consecutive-stable-cycles counter, and emits edge pulses.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   din        in   raw asynchronous level
//   q          out  debounced registered level
//   rise       out  one-cycle pulse, first cycle q is 1 after 0
//   fall       out  one-cycle pulse, first cycle q is 0 after 1
//   glitch_cnt out  saturating count of aborted transitions
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GW            = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    output logic          q,
    output logic          rise,
    output logic          fall,
    output logic [GW-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        RISING  = 2'b01,
        HIGH    = 2'b11,
        FALLING = 2'b10
    } state_e;

    localparam logic [7:0] LAST      = 8'(STABLE_CYCLES - 1);
    localparam bit         ONE_CYCLE = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GW-1:0]          glitch_q, glitch_d;
    logic                   glitch_inc;

    // Synchronizer chain; only its last stage is seen by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            q_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;

        case (state_q)
            LOW: begin
                q_d = 1'b0;
                if (s) begin
                    if (ONE_CYCLE) begin
                        state_d = HIGH;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = RISING;
                        cnt_d   = 8'd1;
                    end
                end
            end

            RISING: begin
                if (!s) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = HIGH;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            HIGH: begin
                q_d = 1'b1;
                if (!s) begin
                    if (ONE_CYCLE) begin
                        state_d = LOW;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = FALLING;
                        cnt_d   = 8'd1;
                    end
                end
            end

            FALLING: begin
                if (s) begin
                    state_d    = HIGH;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = LOW;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = LOW;
                q_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Debug counter holds at all-ones rather than wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_inc && (glitch_q != '1)) begin
            glitch_d = glitch_q + GW'(1);
        end
    end

    assign q          = q_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;

endmodule
